can_crc_check: RTL and testbench

- Receive-side CRC-15 checker that sits directly downstream of the bit destuffer and runs in parallel with the receiver.
- Samples the serial CAN line with its own bit timing and drops stuff bits flagged by the destuffer.
- Parses the frame far enough to locate the end of the data field.
- Computes the CAN CRC-15 over SOF..data, captures the received CRC field, checks the CRC delimiter and reports pass/fail once per frame.

---
 rtl/can_crc_check.sv | 155 +++++++++++++++
 tb/tb_can_crc_check.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/can_crc_check.sv
// Receive-side CAN CRC-15 checker. It samples the destuffed bit stream and follows the frame up to the
// CRC delimiter. It reports a pass/fail result once per frame.
module can_crc_check #(
   parameter int          CLKS_PER_BIT = 10,
   parameter logic [14:0] CRC_POLY     = 15'h4599
) (
   input  logic        i_Clock,
   input  logic        i_Rst_n,
   input  logic        i_Rx_Serial,
   input  logic        i_Ignora_Bit,
   input  logic        i_Erro_Flag,
   output logic        o_Busy,
   output logic        o_Crc_Valid,
   output logic        o_Crc_Ok,
   output logic        o_Crc_Err,
   output logic        o_Abort,
   output logic [14:0] o_Crc_Calc,
   output logic [14:0] o_Crc_Rx
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT) + 1;

   typedef enum logic [2:0] {IDLE, SOF, ARB, EXT, CTRL, DATA, CRC, DELIM} state_t;

   state_t        state, state_next;
   logic [CW-1:0] clk_cnt;
   logic [6:0]    bit_cnt;
   logic          rx_prev;
   logic          rtr;
   logic [2:0]    dlc_hi;
   logic [3:0]    len;
   logic [14:0]   crc;
   logic [14:0]   crc_step;
   logic [3:0]    dlc_full;
   logic [3:0]    len_now;
   logic          sof_point;
   logic          sample;
   logic          proc;
   logic          sof_go;
   logic          freeze;
   logic          done;
   logic          abort;
   logic          crc_match;

   assign sof_point = (state == SOF) && (clk_cnt == CW'(HALF - 1));
   assign sample    = (state inside {ARB, EXT, CTRL, DATA, CRC, DELIM}) &&
                      (clk_cnt == CW'(CLKS_PER_BIT - 1));
   assign proc      = sample && !i_Ignora_Bit && (state != DELIM);
   assign crc_step  = {crc[13:0], 1'b0} ^ ((i_Rx_Serial ^ crc[14]) ? CRC_POLY : 15'd0);
   assign crc_match = (o_Crc_Calc == o_Crc_Rx) && i_Rx_Serial;

   // The last DLC bit is still on the line when the length is decided.
   assign dlc_full  = {dlc_hi, i_Rx_Serial};
   assign len_now   = rtr ? 4'd0 : ((dlc_full > 4'd8) ? 4'd8 : dlc_full);

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      sof_go     = 1'b0;
      freeze     = 1'b0;
      done       = 1'b0;
      abort      = 1'b0;
      if (state != IDLE && i_Erro_Flag) begin
         state_next = IDLE;
         abort      = 1'b1;
      end else begin
         case (state)
            IDLE:  if (rx_prev && !i_Rx_Serial) state_next = SOF;
            SOF:   if (sof_point) begin
                      if (i_Rx_Serial) state_next = IDLE;
                      else begin
                         state_next = ARB;
                         sof_go     = 1'b1;
                      end
                   end
            ARB:   if (proc && bit_cnt == 7'd12) state_next = i_Rx_Serial ? EXT : CTRL;
            EXT:   if (proc && bit_cnt == 7'd19) state_next = CTRL;
            CTRL:  if (proc && bit_cnt == 7'd4) begin
                      if (len_now == 4'd0) begin
                         state_next = CRC;
                         freeze     = 1'b1;
                      end else state_next = DATA;
                   end
            DATA:  if (proc && bit_cnt == {len, 3'b000} - 7'd1) begin
                      state_next = CRC;
                      freeze     = 1'b1;
                   end
            CRC:   if (proc && bit_cnt == 7'd14) state_next = DELIM;
            DELIM: if (sample) begin
                      state_next = IDLE;
                      done       = 1'b1;
                   end
            default: state_next = IDLE;
         endcase
      end
   end

   // Bit timing, frame bookkeeping and the CRC datapath. Every bit counter restarts when the state changes.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rx_prev     <= 1'b0;
         clk_cnt     <= '0;
         bit_cnt     <= '0;
         rtr         <= 1'b0;
         dlc_hi      <= '0;
         len         <= '0;
         crc         <= '0;
         o_Busy      <= 1'b0;
         o_Crc_Valid <= 1'b0;
         o_Crc_Ok    <= 1'b0;
         o_Crc_Err   <= 1'b0;
         o_Abort     <= 1'b0;
         o_Crc_Calc  <= '0;
         o_Crc_Rx    <= '0;
      end else begin
         rx_prev     <= i_Rx_Serial;
         o_Crc_Valid <= done;
         o_Abort     <= abort;

         if (state == IDLE || sof_point || sample) clk_cnt <= '0;
         else                                      clk_cnt <= clk_cnt + CW'(1);

         if (state_next != state) bit_cnt <= '0;
         else if (proc)           bit_cnt <= bit_cnt + 7'd1;

         if (sof_go) crc <= '0;
         else if (proc && (state inside {ARB, EXT, CTRL, DATA})) crc <= crc_step;

         if (proc && ((state == ARB && bit_cnt == 7'd11) || (state == EXT && bit_cnt == 7'd18)))
            rtr <= i_Rx_Serial;
         if (proc && state == CTRL) dlc_hi <= {dlc_hi[1:0], i_Rx_Serial};
         if (state == CTRL && state_next == DATA) len <= len_now;

         if (freeze) o_Crc_Calc <= crc_step;
         if (proc && state == CRC) o_Crc_Rx <= {o_Crc_Rx[13:0], i_Rx_Serial};

         if (sof_go)              o_Busy <= 1'b1;
         else if (abort || done)  o_Busy <= 1'b0;

         if (sof_go || abort) begin
            o_Crc_Ok  <= 1'b0;
            o_Crc_Err <= 1'b0;
         end else if (done) begin
            o_Crc_Ok  <= crc_match;
            o_Crc_Err <= !crc_match;
         end
      end
   end

endmodule

// File: tb/tb_can_crc_check.sv
// Directed bench for can_crc_check. It builds unstuffed frames, computes their CRC with a reference model
// and sends them with stuff bits that are flagged the same way the destuffer flags them.
`timescale 1ns/1ps
module tb_can_crc_check;

   localparam int CPB = 10;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx    = 1'b1;
   logic        ign   = 1'b0;
   logic        err   = 1'b0;
   logic        busy, valid, ok, crc_err, abort;
   logic [14:0] calc, crc_rx;

   int checks    = 0;
   int failures  = 0;
   int valid_cnt = 0;
   int abort_cnt = 0;
   bit frame_q[$];

   can_crc_check #(.CLKS_PER_BIT(CPB), .CRC_POLY(15'h4599)) dut (
      .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx), .i_Ignora_Bit(ign), .i_Erro_Flag(err),
      .o_Busy(busy), .o_Crc_Valid(valid), .o_Crc_Ok(ok), .o_Crc_Err(crc_err), .o_Abort(abort),
      .o_Crc_Calc(calc), .o_Crc_Rx(crc_rx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid) valid_cnt++;
      if (abort) abort_cnt++;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [14:0] crc_model();
      logic [14:0] c = '0;
      logic        nxt;
      foreach (frame_q[i]) begin
         nxt = frame_q[i] ^ c[14];
         c   = {c[13:0], 1'b0};
         if (nxt) c = c ^ 15'h4599;
      end
      return c;
   endfunction

   task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                              input logic [7:0] fill);
      int nbytes;
      frame_q.delete();
      frame_q.push_back(1'b0);
      for (int i = 10; i >= 0; i--) frame_q.push_back(id[i]);
      frame_q.push_back(rtr);
      frame_q.push_back(1'b0);
      frame_q.push_back(1'b0);
      for (int i = 3; i >= 0; i--) frame_q.push_back(dlc[i]);
      nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
      for (int b = 0; b < nbytes; b++)
         for (int i = 7; i >= 0; i--) frame_q.push_back(fill[i]);
   endtask

   task automatic send_bit(input bit b, input logic stuff);
      rx  = b;
      ign = stuff;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // A trailing stuff bit is left out because it would land on the delimiter sample.
   task automatic applyStimulus(input logic [14:0] crc_field, input logic delim, input int err_at);
      bit stream[$];
      bit last    = 1'b1;
      int run     = 0;
      bit aborted = 1'b0;
      int n;
      stream = frame_q;
      for (int i = 14; i >= 0; i--) stream.push_back(crc_field[i]);
      n = stream.size();
      for (int i = 0; i < n; i++) begin
         if (i == err_at) begin
            rx  = stream[i];
            ign = 1'b0;
            repeat (3) @(posedge clk);
            #1 err = 1'b1;
            @(posedge clk);
            #1 err = 1'b0;
            rx = 1'b1;
            aborted = 1'b1;
            break;
         end
         send_bit(stream[i], 1'b0);
         if (stream[i] == last) run++;
         else begin
            run  = 1;
            last = stream[i];
         end
         if (run == 5 && i < n - 1) begin
            send_bit(!last, 1'b1);
            last = !last;
            run  = 1;
         end
      end
      if (!aborted) send_bit(delim, 1'b0);
      ign = 1'b0;
      rx  = 1'b1;
      repeat (4 * CPB) @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input string tag, input logic [14:0] crc_field, input logic delim,
                            input logic [14:0] exp_calc, input logic exp_ok);
      int v0 = valid_cnt;
      int a0 = abort_cnt;
      applyStimulus(crc_field, delim, -1);
      checkOutput({tag, "_calc"},  32'(calc),      32'(exp_calc));
      checkOutput({tag, "_rx"},    32'(crc_rx),    32'(crc_field));
      checkOutput({tag, "_valid"}, 32'(valid_cnt - v0), 32'd1);
      checkOutput({tag, "_abort"}, 32'(abort_cnt - a0), 32'd0);
      checkOutput({tag, "_ok"},    32'(ok),        32'(exp_ok));
      checkOutput({tag, "_err"},   32'(crc_err),   32'(!exp_ok));
      checkOutput({tag, "_busy"},  32'(busy),      32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_busy"},  32'(busy),    32'd0);
      checkOutput({tag, "_valid"}, 32'(valid),   32'd0);
      checkOutput({tag, "_ok"},    32'(ok),      32'd0);
      checkOutput({tag, "_err"},   32'(crc_err), 32'd0);
      checkOutput({tag, "_abort"}, 32'(abort),   32'd0);
      checkOutput({tag, "_calc"},  32'(calc),    32'd0);
      checkOutput({tag, "_rx"},    32'(crc_rx),  32'd0);
   endtask

   initial begin
      logic [14:0] exp_crc;
      int          v0, a0;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      #1;

      // Plain all-zero data frame, then the same frame with a corrupted CRC field.
      build_frame(11'h000, 1'b0, 4'd0, 8'h00);
      run_frame("t1", 15'h0000, 1'b1, 15'h0000, 1'b1);
      run_frame("t2", 15'h0001, 1'b1, 15'h0000, 1'b0);

      // Remote frame with a good delimiter, then with a dominant delimiter.
      build_frame(11'h000, 1'b1, 4'd0, 8'h00);
      run_frame("t3", 15'h73C5, 1'b1, 15'h73C5, 1'b1);
      run_frame("t3_delim", 15'h73C5, 1'b0, 15'h73C5, 1'b0);

      // An oversized DLC is clamped to 8 bytes; a frame of ones exercises stuffing.
      build_frame(11'h123, 1'b0, 4'd12, 8'h55);
      exp_crc = crc_model();
      run_frame("t4", exp_crc, 1'b1, exp_crc, 1'b1);
      build_frame(11'h7FF, 1'b0, 4'd2, 8'hFF);
      exp_crc = crc_model();
      run_frame("t4_ones", exp_crc, 1'b1, exp_crc, 1'b1);

      // Stuff error during the data field.
      build_frame(11'h123, 1'b0, 4'd12, 8'h55);
      exp_crc = crc_model();
      v0 = valid_cnt;
      a0 = abort_cnt;
      applyStimulus(exp_crc, 1'b1, 30);
      checkOutput("t5_abort", 32'(abort_cnt - a0), 32'd1);
      checkOutput("t5_valid", 32'(valid_cnt - v0), 32'd0);
      checkOutput("t5_busy",  32'(busy),    32'd0);
      checkOutput("t5_ok",    32'(ok),      32'd0);
      checkOutput("t5_err",   32'(crc_err), 32'd0);
      build_frame(11'h000, 1'b0, 4'd0, 8'h00);
      run_frame("t5_clean", 15'h0000, 1'b1, 15'h0000, 1'b1);

      // A short dominant glitch must not start a frame or disturb the held result.
      v0 = valid_cnt;
      a0 = abort_cnt;
      rx = 1'b0;
      repeat (3) @(posedge clk);
      #1 rx = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      #1;
      checkOutput("t6_glitch_busy",  32'(busy), 32'd0);
      checkOutput("t6_glitch_ok",    32'(ok),   32'd1);
      checkOutput("t6_glitch_valid", 32'(valid_cnt - v0), 32'd0);
      checkOutput("t6_glitch_abort", 32'(abort_cnt - a0), 32'd0);

      // Reset in the middle of a frame that follows a passing remote frame.
      build_frame(11'h000, 1'b1, 4'd0, 8'h00);
      run_frame("t6_pre", 15'h73C5, 1'b1, 15'h73C5, 1'b1);
      a0 = abort_cnt;
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      checkOutput("t6_mid_busy", 32'(busy),    32'd1);
      checkOutput("t6_mid_ok",   32'(ok),      32'd0);
      checkOutput("t6_mid_err",  32'(crc_err), 32'd0);
      checkOutput("t6_mid_calc", 32'(calc),    32'h73C5);
      checkOutput("t6_mid_rx",   32'(crc_rx),  32'h73C5);
      #3 rst_n = 1'b0;
      #1;
      check_all_zero("t6_rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      #1;
      checkOutput("t6_rst_abort", 32'(abort_cnt - a0), 32'd0);
      checkOutput("t6_rst_busy",  32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
